float_contract_round: RTL and testbench

FLOAT_CONTRACT_ROUND -- requirements
Module: float_contract_round

---
 rtl/float_contract_round.sv | 166 ++++++++++++++++
 tb/tb_float_contract_round.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_contract_round.sv
// float_contract_round
//   Rounds a contracted float (truncated toward zero plus trailing/sticky
//   side bits) to round-to-nearest-even. The block is a 2-stage
//   valid/ready pipeline:
//     S1 registers the input beat and the roundUp decision.
//     S2 registers the rounded result and the per-beat flags.
//   It also keeps a saturating count of inexact output transfers.
// Ports
//   clock, resetn                  clock, async active-low reset
//   inValid/inReady                input handshake
//   inSign/inExp/inFrac            contracted float (truncated)
//   inTrailing/inSticky/inIsNan    contraction side outputs
//   outValid/outReady              output handshake
//   outSign/outExp/outFrac         rounded float
//   outInexact/outOverflow         per-beat flags
//   inexactCount/clearCount        inexact event counter and its clear
module float_contract_round #(
  parameter int EXP                   = 8,
  parameter int FRAC                  = 7,
  parameter int TRAILING_BITS         = 2,
  parameter int SATURATE_TO_MAX_FLOAT = 0
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic                     inSign,
  input  logic [EXP-1:0]           inExp,
  input  logic [FRAC-1:0]          inFrac,
  input  logic [TRAILING_BITS-1:0] inTrailing,
  input  logic                     inSticky,
  input  logic                     inIsNan,
  output logic                     outValid,
  input  logic                     outReady,
  output logic                     outSign,
  output logic [EXP-1:0]           outExp,
  output logic [FRAC-1:0]          outFrac,
  output logic                     outInexact,
  output logic                     outOverflow,
  output logic [15:0]              inexactCount,
  input  logic                     clearCount
);
  localparam int W = EXP + FRAC + 1;
  localparam logic [EXP-1:0]           EXP_ONES  = '1;
  localparam logic [EXP-1:0]           EXP_MAXF  = EXP_ONES - EXP'(1);
  localparam logic [FRAC-1:0]          QNAN_FRAC = FRAC'(1) << (FRAC - 1);
  // Trailing bits below the guard bit.
  localparam logic [TRAILING_BITS-1:0] LO_MASK   =
    TRAILING_BITS'((1 << (TRAILING_BITS - 1)) - 1);

  // ---------------- handshake ----------------
  logic s1Valid_q, s2Valid_q;
  logic s2Load, s1Load;

  // S2 takes S1 whenever it is empty or its beat leaves this cycle; S1 then
  // frees up as well, so S1 loads under the same condition or when empty.
  assign s2Load  = !s2Valid_q || outReady;
  assign s1Load  = !s1Valid_q || s2Load;
  assign inReady = s1Load;
  assign outValid = s2Valid_q;

  // ---------------- S1 ----------------
  logic                s1Sign_q, s1RoundUp_q, s1Inexact_q, s1Nan_q;
  logic [EXP-1:0]      s1Exp_q;
  logic [FRAC-1:0]     s1Frac_q;
  logic                guard, rest, roundUp;

  assign guard   = inTrailing[TRAILING_BITS-1];
  assign rest    = (|(inTrailing & LO_MASK)) | inSticky;
  assign roundUp = guard && (rest || inFrac[0]);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1Valid_q   <= 1'b0;
      s1Sign_q    <= 1'b0;
      s1Exp_q     <= '0;
      s1Frac_q    <= '0;
      s1RoundUp_q <= 1'b0;
      s1Inexact_q <= 1'b0;
      s1Nan_q     <= 1'b0;
    end else if (s1Load) begin
      s1Valid_q   <= inValid;
      s1Sign_q    <= inSign;
      s1Exp_q     <= inExp;
      s1Frac_q    <= inFrac;
      s1RoundUp_q <= roundUp;
      s1Inexact_q <= (|inTrailing) | inSticky;
      s1Nan_q     <= inIsNan;
    end
  end

  // ---------------- S2 ----------------
  logic [W-1:0]    sum;
  logic            isInf, ovf;
  logic [EXP-1:0]  s2Exp_d;
  logic [FRAC-1:0] s2Frac_d;
  logic            s2Inexact_d, s2Ovf_d;

  // Incrementing {exp,frac} lets a fraction carry bump the exponent, which
  // also promotes a denormal to the smallest normal.
  assign sum   = {1'b0, s1Exp_q, s1Frac_q} + W'(s1RoundUp_q);
  assign isInf = (s1Exp_q == EXP_ONES) && (s1Frac_q == '0);
  assign ovf   = sum[W-1] || (sum[W-2:FRAC] == EXP_ONES);

  always_comb begin
    s2Exp_d     = sum[W-2:FRAC];
    s2Frac_d    = sum[FRAC-1:0];
    s2Inexact_d = s1Inexact_q;
    s2Ovf_d     = 1'b0;
    if (s1Nan_q) begin
      s2Exp_d     = EXP_ONES;
      s2Frac_d    = QNAN_FRAC;
      s2Inexact_d = 1'b0;
    end else if (isInf) begin
      s2Exp_d     = EXP_ONES;
      s2Frac_d    = '0;
      s2Inexact_d = 1'b0;
    end else if (ovf) begin
      s2Ovf_d     = 1'b1;
      s2Inexact_d = 1'b1;
      if (SATURATE_TO_MAX_FLOAT != 0) begin
        s2Exp_d  = EXP_MAXF;
        s2Frac_d = '1;
      end else begin
        s2Exp_d  = EXP_ONES;
        s2Frac_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s2Valid_q   <= 1'b0;
      outSign     <= 1'b0;
      outExp      <= '0;
      outFrac     <= '0;
      outInexact  <= 1'b0;
      outOverflow <= 1'b0;
    end else if (s2Load) begin
      s2Valid_q   <= s1Valid_q;
      outSign     <= s1Sign_q;
      outExp      <= s2Exp_d;
      outFrac     <= s2Frac_d;
      outInexact  <= s2Inexact_d;
      outOverflow <= s2Ovf_d;
    end
  end

  // ---------------- inexact counter ----------------
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clearCount)
      cnt_d = '0;
    else if (outValid && outReady && outInexact && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign inexactCount = cnt_q;
endmodule

// File: tb/tb_float_contract_round.sv
// Bench for float_contract_round: one DUT with overflow-to-inf, one with
// saturation, driven with the same stimulus. A scoreboard queue holds
// accepted beats; the reference rounds by integer arithmetic on the
// value {exp,frac}.trailing with the sticky bit.
module tb_float_contract_round;
  typedef struct {
    logic       s;
    logic [7:0] e;
    logic [6:0] f;
    logic [1:0] t;
    logic       st;
    logic       n;
  } beat_t;

  logic clock, resetn, inValid, outReady, clearCount;
  logic inSign, inSticky, inIsNan;
  logic [7:0] inExp;
  logic [6:0] inFrac;
  logic [1:0] inTrailing;

  logic inReady, outValid, outSign, outInexact, outOverflow;
  logic [7:0] outExp;
  logic [6:0] outFrac;
  logic [15:0] inexactCount;
  logic inReady_s, outValid_s, outSign_s, outInexact_s, outOverflow_s;
  logic [7:0] outExp_s;
  logic [6:0] outFrac_s;
  logic [15:0] inexactCount_s;

  float_contract_round #(.EXP(8), .FRAC(7), .TRAILING_BITS(2), .SATURATE_TO_MAX_FLOAT(0)) dut (
    .clock(clock), .resetn(resetn), .inValid(inValid), .inReady(inReady),
    .inSign(inSign), .inExp(inExp), .inFrac(inFrac), .inTrailing(inTrailing),
    .inSticky(inSticky), .inIsNan(inIsNan), .outValid(outValid), .outReady(outReady),
    .outSign(outSign), .outExp(outExp), .outFrac(outFrac), .outInexact(outInexact),
    .outOverflow(outOverflow), .inexactCount(inexactCount), .clearCount(clearCount));

  float_contract_round #(.EXP(8), .FRAC(7), .TRAILING_BITS(2), .SATURATE_TO_MAX_FLOAT(1)) dut_sat (
    .clock(clock), .resetn(resetn), .inValid(inValid), .inReady(inReady_s),
    .inSign(inSign), .inExp(inExp), .inFrac(inFrac), .inTrailing(inTrailing),
    .inSticky(inSticky), .inIsNan(inIsNan), .outValid(outValid_s), .outReady(outReady),
    .outSign(outSign_s), .outExp(outExp_s), .outFrac(outFrac_s), .outInexact(outInexact_s),
    .outOverflow(outOverflow_s), .inexactCount(inexactCount_s), .clearCount(clearCount));

  wire [17:0] obs   = {outSign, outExp, outFrac, outInexact, outOverflow};
  wire [17:0] obs_s = {outSign_s, outExp_s, outFrac_s, outInexact_s, outOverflow_s};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int tests = 0, fails = 0;
  beat_t q[$];
  logic [15:0] mcount = 0;
  logic acc = 0;
  logic held_v = 0;
  logic [17:0] held, last_obs, last_obs_s;

  // Reference: result fields {sign, exp, frac, inexact, overflow}.
  function automatic logic [17:0] ref_out(beat_t b, bit sat);
    int mag, rem, up;
    logic inex;
    if (b.n) return {b.s, 8'hFF, 7'h40, 2'b00};
    if (b.e == 8'hFF && b.f == 7'h00) return {b.s, 8'hFF, 7'h00, 2'b00};
    mag = int'({b.e, b.f});
    rem = int'(b.t);                       // quarter-ULP units, half ULP = 2
    up  = (rem > 2 || (rem == 2 && (b.st || (mag % 2 == 1)))) ? 1 : 0;
    mag = mag + up;
    inex = (b.t != 2'b00) || b.st;
    if ((mag >> 7) >= 255)
      return sat ? {b.s, 8'hFE, 7'h7F, 2'b11} : {b.s, 8'hFF, 7'h00, 2'b11};
    return {b.s, 8'(mag >> 7), 7'(mag), inex, 1'b0};
  endfunction

  task automatic set_beat(beat_t b);
    inSign = b.s; inExp = b.e; inFrac = b.f;
    inTrailing = b.t; inSticky = b.st; inIsNan = b.n;
  endtask

  function automatic beat_t mk(logic s, logic [7:0] e, logic [6:0] f,
                               logic [1:0] t, logic st, logic n);
    beat_t b;
    b.s = s; b.e = e; b.f = f; b.t = t; b.st = st; b.n = n;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    logic [7:0] es[5] = '{8'h00, 8'h01, 8'h7F, 8'hFE, 8'hFF};
    b.s  = 1'($urandom);
    b.e  = ($urandom % 3 == 0) ? 8'($urandom) : es[$urandom % 5];
    b.f  = ($urandom % 3 == 0) ? 7'h7F : 7'($urandom);
    if (b.e == 8'hFF && $urandom % 2 == 0) b.f = 7'h00;
    b.t  = 2'($urandom);
    b.st = 1'($urandom);
    b.n  = ($urandom % 12 == 0);
    return b;
  endfunction

  // Samples on the falling edge, then returns 1 time unit after the next
  // rising edge so the caller can drive new inputs.
  task automatic tick();
    beat_t b;
    logic [17:0] e0, e1;
    logic xinex;
    @(negedge clock);
    acc = 1'b0;
    if (resetn) begin
      tests++;
      assert (inexactCount === mcount) else begin
        fails++; $error("FAIL count obs=%0d exp=%0d", inexactCount, mcount);
      end
      if (held_v && outValid) begin
        tests++;
        assert (obs === held) else begin
          fails++; $error("FAIL stall_stable obs=%h exp=%h", obs, held);
        end
      end
      held_v = outValid && !outReady;
      held   = obs;
      xinex  = 1'b0;
      if (outValid && outReady) begin
        tests++;
        assert (q.size() > 0) else begin
          fails++; $error("FAIL spurious_out obs=%h exp=none", obs);
        end
        if (q.size() > 0) begin
          b  = q.pop_front();
          e0 = ref_out(b, 1'b0);
          e1 = ref_out(b, 1'b1);
          last_obs = obs; last_obs_s = obs_s;
          xinex = e0[1];
          tests++;
          assert (obs === e0) else begin
            fails++; $error("FAIL out obs=%h exp=%h", obs, e0);
          end
          tests++;
          assert ({obs_s, outValid_s, inReady_s} === {e1, outValid, inReady}) else begin
            fails++; $error("FAIL out_sat obs=%h exp=%h", obs_s, e1);
          end
        end
      end
      if (clearCount) mcount = 16'd0;
      else if (xinex && mcount != 16'hFFFF) mcount = mcount + 16'd1;
      if (inValid && inReady) begin
        b = mk(inSign, inExp, inFrac, inTrailing, inSticky, inIsNan);
        q.push_back(b);
        acc = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send(beat_t b);
    set_beat(b);
    inValid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (acc) break;
    end
    tests++;
    assert (acc) else begin
      fails++; $error("FAIL send_timeout obs=%0d exp=1", acc);
    end
    inValid = 1'b0;
  endtask

  task automatic drain();
    outReady = 1'b1;
    for (int i = 0; i < 60 && q.size() > 0; i++) tick();
    tests++;
    assert (q.size() == 0) else begin
      fails++; $error("FAIL drain_timeout obs=%0d exp=0", q.size());
    end
  endtask

  task automatic chk(string tag, logic [17:0 ]o, logic [17:0] e);
    tests++;
    assert (o === e) else begin
      fails++; $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  initial begin
    beat_t bp[5];
    int k;
    inValid = 0; outReady = 1; clearCount = 0;
    set_beat(mk(0, 8'h00, 7'h00, 2'b00, 0, 0));
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("reset_state", {outValid, outInexact, outOverflow, inexactCount[0]}, 4'b0000);
    tests++;
    assert (inexactCount === 16'd0) else begin
      fails++; $error("FAIL reset_count obs=%0d exp=0", inexactCount);
    end
    @(posedge clock); @(posedge clock); #1;
    resetn = 1'b1;
    tests++;
    assert (inReady === 1'b1) else begin
      fails++; $error("FAIL ready_after_reset obs=%b exp=1", inReady);
    end

    // Directed rounding cases.
    send(mk(0, 8'h7F, 7'h00, 2'b10, 0, 0)); drain();
    chk("tie_even_down", last_obs, {1'b0, 8'h7F, 7'h00, 2'b10});
    send(mk(0, 8'h7F, 7'h01, 2'b10, 0, 0)); drain();
    chk("tie_even_up", last_obs, {1'b0, 8'h7F, 7'h02, 2'b10});
    send(mk(1, 8'h7F, 7'h7F, 2'b11, 0, 0)); drain();
    chk("carry_exp", last_obs, {1'b1, 8'h80, 7'h00, 2'b10});
    send(mk(0, 8'h00, 7'h7F, 2'b10, 1, 0)); drain();
    chk("denorm_promote", last_obs, {1'b0, 8'h01, 7'h00, 2'b10});
    send(mk(0, 8'hFE, 7'h7F, 2'b10, 1, 0)); drain();
    chk("ovf_inf", last_obs, {1'b0, 8'hFF, 7'h00, 2'b11});
    chk("ovf_sat", last_obs_s, {1'b0, 8'hFE, 7'h7F, 2'b11});
    send(mk(1, 8'hFF, 7'h05, 2'b11, 0, 1)); drain();
    chk("nan", last_obs, {1'b1, 8'hFF, 7'h40, 2'b00});
    send(mk(1, 8'hFF, 7'h00, 2'b00, 0, 0)); drain();
    chk("inf_pass", last_obs, {1'b1, 8'hFF, 7'h00, 2'b00});
    send(mk(1, 8'h00, 7'h00, 2'b01, 0, 0)); drain();
    chk("neg_zero", last_obs, {1'b1, 8'h00, 7'h00, 2'b10});

    // Backpressure: outReady low for the first 4 cycles of a 5-beat stream.
    for (int i = 0; i < 5; i++) bp[i] = mk(0, 8'(8'h10 + i), 7'(i * 9), 2'(i), 0, 0);
    k = 0;
    for (int c = 0; c < 60 && (k < 5 || q.size() > 0); c++) begin
      outReady = (c >= 4);
      if (k < 5) begin set_beat(bp[k]); inValid = 1'b1; end
      else inValid = 1'b0;
      tick();
      if (acc) k++;
      if (c == 2) chk("bp_ready_drop", {28'(k), inReady}, {28'd2, 1'b0});
    end
    inValid = 1'b0;
    chk("bp_all_out", {28'(k), 1'b0}, {28'd5, 1'b0});
    drain();

    // Counter: clear, 3 inexact beats, then clear racing an inexact transfer.
    clearCount = 1'b1; tick(); clearCount = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(0, 8'h40, 7'(i), 2'b01, 0, 0));
    drain();
    tick();
    chk("count3", {2'b00, inexactCount}, 18'd3);
    outReady = 1'b0;
    send(mk(0, 8'h41, 7'h11, 2'b01, 0, 0));
    for (int i = 0; i < 10 && !outValid; i++) tick();
    outReady = 1'b1; clearCount = 1'b1;
    tick();
    clearCount = 1'b0;
    tick();
    chk("clear_priority", {2'b00, inexactCount}, 18'd0);

    // Reset with two beats in flight.
    outReady = 1'b0;
    send(mk(0, 8'h20, 7'h01, 2'b01, 0, 0));
    send(mk(0, 8'h21, 7'h02, 2'b01, 0, 0));
    #2 resetn = 1'b0;
    #1;
    chk("reset_flush", {17'd0, outValid}, 18'd0);
    q.delete(); mcount = 16'd0;
    tick(); tick();
    resetn = 1'b1;
    outReady = 1'b1;
    chk("ready_after_rst2", {17'd0, inReady}, 18'd1);
    for (int i = 0; i < 6; i++) tick();

    // Random traffic with random backpressure and occasional clears.
    for (int c = 0; c < 400; c++) begin
      if (!inValid || acc) begin
        if ($urandom % 4 != 0) begin set_beat(rand_beat()); inValid = 1'b1; end
        else inValid = 1'b0;
      end
      outReady   = ($urandom % 4 != 0);
      clearCount = ($urandom % 40 == 0);
      tick();
    end
    inValid = 1'b0; clearCount = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
